// File: rtl/renkon_conv_tree_25_if.sv
// renkon_pkg: shared datapath constants for the convolution tree.
// renkon_conv_if: window/filter inputs and feature-map output bundle.
package renkon_pkg;
    localparam int DWIDTH = 16;
    localparam int FL     = 8;
    localparam int D_CONV = 6;
    localparam int TAPS   = 25;
    localparam int TWIDTH = DWIDTH + 5;
endpackage

interface renkon_conv_if;
    import renkon_pkg::*;

    logic signed [DWIDTH-1:0] pixel  [TAPS];
    logic signed [DWIDTH-1:0] weight [TAPS];
    logic signed [DWIDTH-1:0] fmap;

    modport master (
        output pixel,
        output weight,
        input  fmap
    );

    modport slave (
        input  pixel,
        input  weight,
        output fmap
    );
endinterface

// File: rtl/renkon_conv_tree_25.sv
// renkon_conv_tree_25: 25-tap fixed-point multiply-add tree.
// One 5x5 window per cycle in, its dot product out D_CONV cycles later.
module renkon_conv_tree_25
    import renkon_pkg::*;
(
    input logic          clk,
    input logic          xrst,
    renkon_conv_if.slave bus
);

    function automatic logic signed [TWIDTH-1:0] sx(
        input logic signed [DWIDTH-1:0] v
    );
        return {{(TWIDTH-DWIDTH){v[DWIDTH-1]}}, v};
    endfunction

    logic signed [2*DWIDTH-1:0] w_full [TAPS];
    logic signed [DWIDTH-1:0]   w_prod [TAPS];
    logic                       w_unused;

    logic signed [DWIDTH-1:0] r_s1 [TAPS];
    logic signed [TWIDTH-1:0] r_l2 [13];
    logic signed [TWIDTH-1:0] r_l3 [7];
    logic signed [TWIDTH-1:0] r_l4 [4];
    logic signed [TWIDTH-1:0] r_l5 [2];
    logic signed [TWIDTH-1:0] r_l6;

    // Slicing [FL+DWIDTH-1:FL] is the arithmetic shift plus wrap in one step.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            w_full[i] = bus.pixel[i] * bus.weight[i];
            w_prod[i] = w_full[i][FL+DWIDTH-1:FL];
        end
    end

    always_comb begin
        w_unused = ^r_l6[TWIDTH-1:DWIDTH];
        for (int i = 0; i < TAPS; i++) begin
            w_unused = w_unused
                     ^ (^w_full[i][2*DWIDTH-1:FL+DWIDTH])
                     ^ (^w_full[i][FL-1:0]);
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < TAPS; i++) r_s1[i] <= '0;
            for (int i = 0; i < 13; i++)   r_l2[i] <= '0;
            for (int i = 0; i < 7; i++)    r_l3[i] <= '0;
            for (int i = 0; i < 4; i++)    r_l4[i] <= '0;
            for (int i = 0; i < 2; i++)    r_l5[i] <= '0;
            r_l6 <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                r_s1[i] <= w_prod[i];
            end
            // Odd leftovers ride along one level at a time.
            for (int i = 0; i < 12; i++) begin
                r_l2[i] <= sx(r_s1[2*i]) + sx(r_s1[2*i+1]);
            end
            r_l2[12] <= sx(r_s1[24]);
            for (int i = 0; i < 6; i++) begin
                r_l3[i] <= r_l2[2*i] + r_l2[2*i+1];
            end
            r_l3[6] <= r_l2[12];
            for (int i = 0; i < 3; i++) begin
                r_l4[i] <= r_l3[2*i] + r_l3[2*i+1];
            end
            r_l4[3] <= r_l3[6];
            for (int i = 0; i < 2; i++) begin
                r_l5[i] <= r_l4[2*i] + r_l4[2*i+1];
            end
            r_l6 <= r_l5[0] + r_l5[1];
        end
    end

    assign bus.fmap = r_l6[DWIDTH-1:0];

endmodule

// File: tb/tb_renkon_conv_tree_25.sv
// tb_renkon_conv_tree_25: directed and random checks of the conv tree
// against an integer dot-product model with a latency queue.
module tb_renkon_conv_tree_25;
    import renkon_pkg::*;

    logic clk;
    logic xrst;
    int   checks;
    int   errors;
    int   q[$];

    renkon_conv_if bus ();

    renkon_conv_tree_25 dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrap16(input longint v);
        longint m;
        m = ((v % 65536) + 65536) % 65536;
        if (m >= 32768) m = m - 65536;
        return int'(m);
    endfunction

    function automatic int model();
        longint acc;
        longint p;
        acc = 0;
        for (int i = 0; i < TAPS; i++) begin
            p = longint'(bus.pixel[i]) * longint'(bus.weight[i]);
            p = p >>> FL;
            acc += wrap16(p);
        end
        return wrap16(acc);
    endfunction

    task automatic set_all(input int p, input int w);
        for (int i = 0; i < TAPS; i++) begin
            bus.pixel[i]  = 16'(p);
            bus.weight[i] = 16'(w);
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < TAPS; i++) begin
            bus.pixel[i]  = 16'($urandom);
            bus.weight[i] = 16'($urandom);
        end
    endtask

    task automatic prime();
        q.delete();
        for (int i = 0; i < D_CONV - 1; i++) q.push_back(0);
    endtask

    // Push the current window's result, clock once, return what is due now.
    task automatic step(output logic signed [15:0] got,
                        output logic signed [15:0] exp);
        q.push_back(model());
        @(posedge clk);
        #1;
        exp = 16'(q.pop_front());
        got = bus.fmap;
    endtask

    task automatic test_reset();
        logic signed [15:0] got, exp;
        set_all(0, 0);
        xrst = 1'b0;
        #22;
        checks++;
        if (bus.fmap !== 16'sd0) begin
            errors++;
            $display("FAIL reset_hold fmap=%0d want=0", bus.fmap);
        end
        @(posedge clk);
        #1;
        xrst = 1'b1;
        prime();
        for (int k = 0; k < 3; k++) begin
            step(got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_idle fmap=%0d want=%0d", got, exp);
            end
        end
    endtask

    task automatic test_unity();
        logic signed [15:0] got, exp;
        set_all(256, 256);
        for (int k = 0; k < 9; k++) begin
            step(got, exp);
            if (k == 0) set_all(0, 0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL unity k=%0d fmap=%0d want=%0d", k, got, exp);
            end
            if (k == D_CONV - 1) begin
                checks++;
                if (got !== 16'sd6400) begin
                    errors++;
                    $display("FAIL unity_const fmap=%0d want=6400", got);
                end
            end
        end
    endtask

    task automatic test_single_tap(input int idx);
        logic signed [15:0] got, exp;
        set_all(0, 0);
        bus.pixel[idx]  = 16'sd512;
        bus.weight[idx] = -16'sd256;
        for (int k = 0; k < D_CONV; k++) begin
            step(got, exp);
            if (k == 0) set_all(0, 0);
        end
        checks++;
        if (got !== -16'sd512 || exp !== -16'sd512) begin
            errors++;
            $display("FAIL tap%0d fmap=%0d want=-512", idx, got);
        end
    endtask

    task automatic test_trunc();
        logic signed [15:0] got, exp;
        set_all(-1, 1);
        for (int k = 0; k < D_CONV; k++) step(got, exp);
        checks++;
        if (got !== -16'sd25) begin
            errors++;
            $display("FAIL trunc_neg fmap=%0d want=-25", got);
        end
        set_all(1, 1);
        for (int k = 0; k < D_CONV; k++) step(got, exp);
        checks++;
        if (got !== 16'sd0) begin
            errors++;
            $display("FAIL trunc_pos fmap=%0d want=0", got);
        end
    endtask

    task automatic test_wrap();
        logic signed [15:0] got, exp;
        set_all(32767, 32767);
        for (int k = 0; k < D_CONV + 2; k++) begin
            step(got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wrap k=%0d fmap=%0d want=%0d", k, got, exp);
            end
        end
        checks++;
        if (got !== -16'sd6400) begin
            errors++;
            $display("FAIL wrap_const fmap=%0d want=-6400", got);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] got, exp;
        int bad;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            set_rand();
            step(got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                if (bad < 10) begin
                    $display("FAIL stream k=%0d fmap=%0d want=%0d",
                             k, got, exp);
                end
                bad++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] got, exp;
        for (int k = 0; k < D_CONV + 2; k++) begin
            set_rand();
            step(got, exp);
        end
        #2;
        xrst = 1'b0;
        #1;
        checks++;
        if (bus.fmap !== 16'sd0) begin
            errors++;
            $display("FAIL reset_async fmap=%0d want=0", bus.fmap);
        end
        set_rand();
        @(posedge clk);
        #1;
        checks++;
        if (bus.fmap !== 16'sd0) begin
            errors++;
            $display("FAIL reset_edge fmap=%0d want=0", bus.fmap);
        end
        xrst = 1'b1;
        prime();
        for (int k = 0; k < D_CONV + 4; k++) begin
            set_rand();
            step(got, exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid k=%0d fmap=%0d want=%0d",
                         k, got, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        xrst   = 1'b0;
        test_reset();
        test_unity();
        test_single_tap(0);
        test_single_tap(24);
        test_trunc();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
